// File: rtl/motor_ramp_scheduler_pkg.sv
// Shared types and helpers for the four-motor duty ramp scheduler.
//   - svc_state_e : ramp engine FSM state (IDLE, then one service slot per motor)
//   - motor_id_t  : 2-bit motor select carried in the top bits of a command byte
//   - OP_*        : control opcodes carried in rx_data[1:0] when rx_data[5] is set
//   - rx_cmd_t    : one received byte split into its command fields
//   - duty_field  : left-aligns the 5-bit speed field to a duty of arbitrary width
package motor_ctrl_pkg;

  localparam int NUM_MOTORS = 4;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    SVC0 = 3'd1,
    SVC1 = 3'd2,
    SVC2 = 3'd3,
    SVC3 = 3'd4
  } svc_state_e;

  typedef logic [1:0] motor_id_t;

  localparam logic [1:0] OP_STOP = 2'b00;
  localparam logic [1:0] OP_CLR  = 2'b01;
  localparam logic [1:0] OP_FWD  = 2'b10;
  localparam logic [1:0] OP_REV  = 2'b11;

  typedef struct packed {
    logic      vld;
    logic      err;
    motor_id_t id;
    logic      is_op;
    logic [1:0] op;
    logic [4:0] spd;
  } rx_cmd_t;

  function automatic rx_cmd_t decode_byte(input logic [7:0] b, input logic vld, input logic err);
    rx_cmd_t d;
    d.vld   = vld;
    d.err   = err;
    d.id    = b[7:6];
    d.is_op = b[5];
    d.op    = b[1:0];
    d.spd   = b[4:0];
    return d;
  endfunction

  // Speed field sits in the top 5 bits of the duty; lower bits are zero.
  function automatic logic [31:0] duty_field(input logic [4:0] spd, input int unsigned duty_w);
    logic [31:0] r;
    r = {27'd0, spd};
    return r << (duty_w - 32'd5);
  endfunction

endpackage

// File: rtl/motor_ramp_scheduler_if.sv
// Received-byte bus from the UART receiver into the scheduler.
//   rx_data  : received byte
//   rx_valid : single-cycle strobe qualifying rx_data / rx_err
//   rx_err   : parity/framing error on this byte
interface motor_ramp_scheduler_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_err;

  modport master (output rx_data, output rx_valid, output rx_err);
  modport slave  (input  rx_data, input  rx_valid, input  rx_err);
endinterface

// File: rtl/motor_ramp_scheduler_watchdog.sv
// Per-motor hall stall watchdog.
//   clk, reset : system clock, async active-high reset
//   hs         : raw 3-bit hall inputs (asynchronous)
//   duty_nz    : motor's applied duty is nonzero
//   clr        : clear-fault command for this motor (wins over a same-cycle fault)
//   fault      : sticky stall fault
module hall_stall_watchdog #(
  parameter int STALL_CYCLES = 64
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] hs,
  input  logic       duty_nz,
  input  logic       clr,
  output logic       fault
);
  localparam int CW = (STALL_CYCLES > 2) ? $clog2(STALL_CYCLES) : 1;

  logic [2:0]    s1_q, s2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          fault_q, fault_d;
  logic          hall_edge;

  // Any change of the synchronized hall word counts as motion.
  assign hall_edge = (s2_q != prev_q);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_q    <= '0;
      s2_q    <= '0;
      prev_q  <= '0;
      cnt_q   <= '0;
      fault_q <= 1'b0;
    end else begin
      s1_q    <= hs;
      s2_q    <= s1_q;
      prev_q  <= s2_q;
      cnt_q   <= cnt_d;
      fault_q <= fault_d;
    end
  end

  always_comb begin
    cnt_d   = cnt_q;
    fault_d = fault_q;
    if (clr) begin
      cnt_d   = '0;
      fault_d = 1'b0;
    end else if (fault_q || hall_edge || !duty_nz) begin
      cnt_d = '0;
    end else if (cnt_q == CW'(STALL_CYCLES - 1)) begin
      fault_d = 1'b1;
      cnt_d   = '0;
    end else begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  assign fault = fault_q;
endmodule

// File: rtl/motor_ramp_scheduler.sv
// Command-driven duty scheduler for four BLDC motors.
//   clk, reset : system clock, async active-high reset
//   rx         : received UART byte bus (slave side)
//   HS1..HS4   : raw hall inputs per motor
//   DutyOut    : applied duty, motor k at [k*DUTY_W +: DUTY_W]
//   Dir        : per-motor direction, 1 = reverse
//   Fault      : per-motor sticky stall fault
//   CmdRej     : one-cycle pulse for a dropped or refused byte
//   Busy       : ramp engine is walking the service slots
// A shared ramp engine visits motors 0..3 on consecutive cycles after each
// tick, moving each applied duty one STEP toward its target.
module motor_ramp_scheduler
  import motor_ctrl_pkg::*;
#(
  parameter int DUTY_W       = 8,
  parameter int RAMP_DIV     = 8,
  parameter int STEP         = 8,
  parameter int STALL_CYCLES = 64
) (
  input  logic                  clk,
  input  logic                  reset,
  motor_ramp_scheduler_if.slave rx,
  input  logic [2:0]            HS1,
  input  logic [2:0]            HS2,
  input  logic [2:0]            HS3,
  input  logic [2:0]            HS4,
  output logic [4*DUTY_W-1:0]   DutyOut,
  output logic [3:0]            Dir,
  output logic [3:0]            Fault,
  output logic                  CmdRej,
  output logic                  Busy
);
  localparam int TW = $clog2(RAMP_DIV);
  localparam logic [DUTY_W:0] STEP_X = (DUTY_W + 1)'(STEP);

  typedef logic [DUTY_W-1:0] duty_t;

  logic [NUM_MOTORS-1:0][DUTY_W-1:0] duty_q, duty_d, target_q, target_d;
  logic [NUM_MOTORS-1:0]             dir_q, dir_d;
  logic [NUM_MOTORS-1:0]             clr_fault, fault, svc_sel;
  logic [NUM_MOTORS-1:0][2:0]        hs;
  logic                              rej_q, rej_d;
  logic [TW-1:0]                     tick_q, tick_d;
  logic                              tick, busy, cmd_acc;
  svc_state_e                        state_q, state_d;
  rx_cmd_t                           cmd;
  duty_t                             cmd_duty;

  assign hs       = {HS4, HS3, HS2, HS1};
  assign cmd      = decode_byte(rx.rx_data, rx.rx_valid, rx.rx_err);
  assign cmd_acc  = cmd.vld & ~cmd.err;
  assign cmd_duty = duty_t'(duty_field(cmd.spd, DUTY_W));

  // One ramp step, done one bit wider so it neither wraps nor passes the target.
  function automatic duty_t ramp_step(input duty_t cur, input duty_t tgt);
    logic [DUTY_W:0] c, t, up, dn;
    c  = {1'b0, cur};
    t  = {1'b0, tgt};
    up = c + STEP_X;
    dn = c - STEP_X;
    ramp_step = cur;
    if (c < t)      ramp_step = (up > t) ? tgt : up[DUTY_W-1:0];
    else if (c > t) ramp_step = (c < STEP_X || dn < t) ? tgt : dn[DUTY_W-1:0];
  endfunction

  // Tick divider
  assign tick   = (tick_q == TW'(RAMP_DIV - 1));
  assign tick_d = tick ? '0 : tick_q + 1'b1;

  // FSM: state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (tick) state_d = SVC0;
      SVC0:    state_d = SVC1;
      SVC1:    state_d = SVC2;
      SVC2:    state_d = SVC3;
      SVC3:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    svc_sel = '0;
    busy    = (state_q != IDLE);
    case (state_q)
      SVC0:    svc_sel = 4'b0001;
      SVC1:    svc_sel = 4'b0010;
      SVC2:    svc_sel = 4'b0100;
      SVC3:    svc_sel = 4'b1000;
      default: svc_sel = '0;
    endcase
  end

  // Command decode and ramp. The ramp result is computed first so that a
  // same-cycle stop overrides it; the ramp always reads the old target.
  always_comb begin
    target_d  = target_q;
    duty_d    = duty_q;
    dir_d     = dir_q;
    clr_fault = '0;
    rej_d     = cmd.vld & (cmd.err | (cmd.is_op & cmd.op[1] & (duty_q[cmd.id] != '0)));
    for (int k = 0; k < NUM_MOTORS; k++) begin
      if (svc_sel[k]) duty_d[k] = fault[k] ? '0 : ramp_step(duty_q[k], target_q[k]);
      if (cmd_acc && cmd.id == motor_id_t'(k)) begin
        if (!cmd.is_op) begin
          target_d[k] = cmd_duty;
        end else begin
          case (cmd.op)
            OP_STOP: begin
              target_d[k] = '0;
              duty_d[k]   = '0;
            end
            OP_CLR:  clr_fault[k] = 1'b1;
            OP_FWD:  if (duty_q[k] == '0) dir_d[k] = 1'b0;
            default: if (duty_q[k] == '0) dir_d[k] = 1'b1;
          endcase
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      tick_q   <= '0;
      duty_q   <= '0;
      target_q <= '0;
      dir_q    <= '0;
      rej_q    <= 1'b0;
    end else begin
      tick_q   <= tick_d;
      duty_q   <= duty_d;
      target_q <= target_d;
      dir_q    <= dir_d;
      rej_q    <= rej_d;
    end
  end

  for (genvar g = 0; g < NUM_MOTORS; g++) begin : g_wd
    hall_stall_watchdog #(.STALL_CYCLES(STALL_CYCLES)) u_wd (
      .clk     (clk),
      .reset   (reset),
      .hs      (hs[g]),
      .duty_nz (|duty_q[g]),
      .clr     (clr_fault[g]),
      .fault   (fault[g])
    );
  end

  assign DutyOut = duty_q;
  assign Dir     = dir_q;
  assign Fault   = fault;
  assign CmdRej  = rej_q;
  assign Busy    = busy;
endmodule
